// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIB_W     : width of one slice operand (one nibble)
//   state_e   : sequencer states
//   cnt_width : bits needed to count NIB nibbles, never less than 1
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/simp_alu74181.sv
// Simplified 4-bit carry-lookahead adder slice (add function of the 74181 only).
// Purely combinational.
//   a, b  : 4-bit operands
//   cin   : carry in
//   s     : a + b + cin, low 4 bits
//   cout  : carry out of bit 3
//   pout  : group propagate, 1 when every bit position propagates (a ^ b all ones)
module simp_alu74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, every term expanded down to cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
    assign pout = &p;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one simp_alu74181 slice a nibble per
// cycle, LSB nibble first, with the carry registered between nibbles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout, ovf, prop)
//   sum  : a + b + cin modulo 2^WIDTH
//   cout : carry out of the MSB nibble
//   ovf  : two's-complement overflow
//   prop : AND of the slice group-propagate over all nibbles
// Results stay on the outputs after the transfer until the next acceptance.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             prop
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             p_acc_q, p_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic [NIB_W-1:0] slice_s;
    logic             slice_cout;
    logic             slice_pout;
    logic [WIDTH-1:0] sum_shift;

    // The slice sits directly on the shift-register outputs; no staging.
    simp_alu74181 u_slice (
        .a    (a_sh_q[NIB_W-1:0]),
        .b    (b_sh_q[NIB_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .pout (slice_pout)
    );

    // New nibble enters at the top so the first one lands at [3:0] after NIB shifts.
    if (NIB > 1) begin : g_sum_shift
        assign sum_shift = {slice_s, sum_q[WIDTH-1:NIB_W]};
    end else begin : g_sum_single
        assign sum_shift = slice_s;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        p_acc_d = p_acc_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    p_acc_d = 1'b1;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                sum_d   = sum_shift;
                carry_d = slice_cout;
                p_acc_d = p_acc_q & slice_pout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            p_acc_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            p_acc_q <= p_acc_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    // After the last nibble the carry register holds the MSB carry-out.
    assign cout      = carry_q;
    assign prop      = p_acc_q;
    assign ovf       = (a_msb_q == b_msb_q) && (sum_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         prop;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         prop;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         prop;
    } res_t;

    vec_t vecs[6];
    res_t exp_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .prop      (prop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv);
        res_t r;
        logic [W:0] full;
        full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
        r.prop = &(av ^ bv);
        return r;
    endfunction

    // Compare DUT outputs against the head of the scoreboard.
    task automatic compare_out(input string tag);
        res_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, sum, e.sum);
            check({tag, "_cout"}, cout, e.cout);
            check({tag, "_ovf"}, ovf, e.ovf);
            check({tag, "_prop"}, prop, e.prop);
        end
    endtask

    // One full operation; hold > 0 keeps out_ready low that many cycles in DONE
    // while pulsing in_valid with different operands.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input res_t e, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, in_ready, 1'b1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(e);
        check({tag, "_busy"}, in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, n, NIB);
        for (int i = 0; i < hold; i++) begin
            a = ~av; b = bv ^ 16'h5A5A; in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
            check({tag, "_hold_sum"}, sum, e.sum);
        end
        in_valid = 1'b0;
        compare_out(tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
        check({tag, "_sum_kept"}, sum, e.sum);
    endtask

    initial begin
        res_t e;
        int n;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_prop", prop, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            e.sum = vecs[i].sum; e.cout = vecs[i].cout;
            e.ovf = vecs[i].ovf; e.prop = vecs[i].prop;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, e, 0);
        end

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i == 0) rb = ra ^ 16'hFFFF;
            run_op($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc), 0);
        end

        // Back-pressure in DONE
        run_op("bp", 16'h1234, 16'h4321, 1'b0, model(16'h1234, 16'h4321, 1'b0), 6);
        run_op("bp_next", 16'hA5A5, 16'h1111, 1'b1, model(16'hA5A5, 16'h1111, 1'b1), 0);

        // Reset in the middle of RUN
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 16'h0000);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        e.sum = 16'h0002; e.cout = 1'b0; e.ovf = 1'b0; e.prop = 1'b0;
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, e, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
